irq_ctl: RTL and testbench

//  Vectored interrupt controller on the 65C02 CPU bus; drives the core's level irq input.

---
 rtl/irq_ctl_pkg.sv | 23 ++
 rtl/irq_sync.sv | 34 +++
 rtl/irq_ctl.sv | 171 +++++++++++++++++
 tb/tb_irq_ctl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the 65C02 vectored interrupt controller:
// register window offsets, FSM states and the IRQ vector addresses.
package irq_ctl_pkg;

   localparam logic [2:0] REG_PEND   = 3'd0;
   localparam logic [2:0] REG_MASK   = 3'd1;
   localparam logic [2:0] REG_EDGE   = 3'd2;
   localparam logic [2:0] REG_POL    = 3'd3;
   localparam logic [2:0] REG_ACTIVE = 3'd4;
   localparam logic [2:0] REG_EOI    = 3'd5;
   localparam logic [2:0] REG_VECL   = 3'd6;
   localparam logic [2:0] REG_VECH   = 3'd7;

   localparam logic [15:0] VEC_LO = 16'hFFFE;
   localparam logic [15:0] VEC_HI = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      VEC     = 2'd1,
      SERVICE = 2'd2
   } state_t;

endpackage

// File: rtl/irq_sync.sv
// Brings the asynchronous interrupt sources into the clock domain, applies
// per-source polarity and flags the cycle in which each active level rises.
module irq_sync #(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NSRC-1:0] src,
   input  logic [NSRC-1:0] pol,
   output logic [NSRC-1:0] act,
   output logic [NSRC-1:0] rise
);

   logic [NSRC-1:0] meta;
   logic [NSRC-1:0] sync;
   logic [NSRC-1:0] act_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta  <= '0;
         sync  <= '0;
         act_q <= '0;
      end else begin
         meta  <= src;
         sync  <= meta;
         act_q <= act;
      end
   end

   // POL=1 means the source is active high, so an inverted POL bit flips it.
   assign act  = sync ^ ~pol;
   assign rise = act & ~act_q;

endmodule

// File: rtl/irq_ctl.sv
// Vectored interrupt controller on the 65C02 bus: pending/mask registers,
// priority selection, and IRQ vector substitution with EOI-terminated service.
module irq_ctl
   import irq_ctl_pkg::*;
#(
   parameter int          NSRC = 8,
   parameter logic [15:0] BASE = 16'hFE00
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [15:0]     AB,
   input  logic            WE,
   input  logic [7:0]      DO,
   output logic [7:0]      DI,
   output logic            DI_sel,
   input  logic [NSRC-1:0] src,
   output logic            irq
);

   state_t state;
   state_t state_nxt;

   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] pend_nxt;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] edge_en;
   logic [NSRC-1:0] pol;
   logic [7:0]      vecl;
   logic [7:0]      vech;
   logic [2:0]      act_id;

   logic [NSRC-1:0] act;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] req;
   logic [NSRC-1:0] w1c;
   logic [NSRC-1:0] clr_vec;
   logic [2:0]      win_id;
   logic            has_req;
   logic            win_hit;
   logic            wr_reg;
   logic            eoi_wr;
   logic            fetch_lo;
   logic            fetch_hi;
   logic            vec_take;
   logic            vech_take;
   logic [7:0]      rd_data;

   irq_sync #(.NSRC(NSRC)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .src     (src),
      .pol     (pol),
      .act     (act),
      .rise    (rise)
   );

   assign win_hit  = (AB[15:3] == BASE[15:3]);
   assign wr_reg   = WE && win_hit;
   assign eoi_wr   = wr_reg && (AB[2:0] == REG_EOI);
   assign fetch_lo = !WE && (AB == VEC_LO);
   assign fetch_hi = !WE && (AB == VEC_HI);
   assign req      = pend & mask;
   assign has_req  = |req;

   // Lowest index wins, so scan downward and let the last hit stand.
   always_comb begin
      win_id = 3'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) win_id = 3'(i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fetch_lo && has_req) state_nxt = VEC;
         VEC:     state_nxt = SERVICE;
         SERVICE: if (eoi_wr) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      irq       = 1'b0;
      vec_take  = 1'b0;
      vech_take = 1'b0;
      case (state)
         IDLE: begin
            irq      = has_req;
            vec_take = fetch_lo && has_req;
         end
         VEC:     vech_take = fetch_hi;
         default: ;
      endcase
   end

   // An edge arriving in the same cycle as a W1C or vector acknowledge must not be lost.
   always_comb begin
      w1c = (wr_reg && (AB[2:0] == REG_PEND)) ? DO[NSRC-1:0] : '0;
      for (int i = 0; i < NSRC; i++) begin
         clr_vec[i]  = vec_take && (win_id == 3'(i));
         pend_nxt[i] = edge_en[i] ? (rise[i] | (pend[i] & ~w1c[i] & ~clr_vec[i]))
                                  : act[i];
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (AB[2:0])
         REG_PEND:   rd_data = 8'(pend);
         REG_MASK:   rd_data = 8'(mask);
         REG_EDGE:   rd_data = 8'(edge_en);
         REG_POL:    rd_data = 8'(pol);
         REG_ACTIVE: rd_data = {state == SERVICE, 4'b0000, act_id};
         REG_VECL:   rd_data = vecl;
         REG_VECH:   rd_data = vech;
         default:    rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend    <= '0;
         mask    <= '0;
         edge_en <= '0;
         pol     <= '0;
         vecl    <= 8'h00;
         vech    <= 8'h00;
         act_id  <= 3'd0;
      end else begin
         pend <= pend_nxt;
         if (wr_reg) begin
            case (AB[2:0])
               REG_MASK: mask    <= DO[NSRC-1:0];
               REG_EDGE: edge_en <= DO[NSRC-1:0];
               REG_POL:  pol     <= DO[NSRC-1:0];
               REG_VECL: vecl    <= DO;
               REG_VECH: vech    <= DO;
               default:  ;
            endcase
         end
         if (vec_take) act_id <= win_id;
      end
   end

   // Read data lands one cycle after the address, like the synchronous RAM it overrides.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         DI     <= 8'h00;
         DI_sel <= 1'b0;
      end else if (vec_take) begin
         DI     <= {vecl[7:4], win_id, 1'b0};
         DI_sel <= 1'b1;
      end else if (vech_take) begin
         DI     <= vech;
         DI_sel <= 1'b1;
      end else if (!WE && win_hit) begin
         DI     <= rd_data;
         DI_sel <= 1'b1;
      end else begin
         DI     <= 8'h00;
         DI_sel <= 1'b0;
      end
   end

endmodule

// File: tb/tb_irq_ctl.sv
// Scoreboard bench for irq_ctl: reads push expected bytes, a negedge monitor
// pops one whenever DI_sel is raised; irq is checked directly by the stimulus.
module tb_irq_ctl;
   import irq_ctl_pkg::*;

   localparam logic [15:0] BASE = 16'hFE00;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] AB;
   logic        WE;
   logic [7:0]  DO;
   logic [7:0]  DI;
   logic        DI_sel;
   logic [7:0]  src;
   logic        irq;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] exp_data[$];
   int         exp_cyc[$];
   string      exp_name[$];

   irq_ctl #(.NSRC(8), .BASE(BASE)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .AB      (AB),
      .WE      (WE),
      .DO      (DO),
      .DI      (DI),
      .DI_sel  (DI_sel),
      .src     (src),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every DI_sel pulse must match the oldest outstanding expectation, in the right cycle.
   initial begin
      logic [7:0] d;
      int         c;
      string      n;
      forever begin
         @(negedge clk);
         if (DI_sel === 1'b1) begin
            checks++;
            if (exp_data.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_override: DI_sel=1 DI=%02h at cycle %0d, required DI_sel=0", DI, cyc);
            end else begin
               d = exp_data.pop_front();
               c = exp_cyc.pop_front();
               n = exp_name.pop_front();
               if (DI !== d || cyc != c) begin
                  errors++;
                  $display("[TB] FAIL %s: DI=%02h at cycle %0d, required %02h at cycle %0d", n, DI, cyc, d, c);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic bus_cycle(input logic [15:0] addr, input logic we, input logic [7:0] data);
      AB = addr;
      WE = we;
      DO = data;
      @(posedge clk);
      #1;
      AB = 16'h0000;
      WE = 1'b0;
      DO = 8'h00;
   endtask

   task automatic read_exp(input logic [15:0] addr, input logic [7:0] expv, input string name);
      exp_data.push_back(expv);
      exp_cyc.push_back(cyc + 1);
      exp_name.push_back(name);
      bus_cycle(addr, 1'b0, 8'h00);
   endtask

   task automatic write_reg(input logic [2:0] off, input logic [7:0] data);
      bus_cycle(BASE + {13'd0, off}, 1'b1, data);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_output(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
      end
   endtask

   task automatic check_byte(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %02h, required %02h", name, actual, expected);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      AB      = BASE;
      WE      = 1'b0;
      DO      = 8'h00;
      src     = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_irq", irq, 1'b0);
      check_output("rst_sel", DI_sel, 1'b0);
      #3 reset_n = 1'b1;
      read_exp(BASE + 16'd0, 8'h00, "reset_pend");
      read_exp(BASE + 16'd1, 8'h00, "reset_mask");

      // Configure: all sources active high, src[2] edge-triggered and enabled.
      write_reg(REG_POL,  8'hFF);
      write_reg(REG_EDGE, 8'h04);
      write_reg(REG_MASK, 8'h04);
      write_reg(REG_VECL, 8'h40);
      write_reg(REG_VECH, 8'h12);
      check_output("mask_no_pend", irq, 1'b0);
      read_exp(BASE + 16'd0, 8'h00, "pend_idle");

      src = 8'h04;
      idle(2);
      check_output("edge_lat2", irq, 1'b0);
      src = 8'h00;
      idle(1);
      check_output("edge_lat3", irq, 1'b1);
      read_exp(BASE + 16'd0, 8'h04, "edge_pend");

      read_exp(VEC_LO, 8'h44, "vec_lo");
      check_output("irq_in_vec", irq, 1'b0);
      read_exp(VEC_HI, 8'h12, "vec_hi");
      check_output("irq_in_service", irq, 1'b0);
      read_exp(BASE + 16'd4, 8'h82, "active_service");
      read_exp(BASE + 16'd0, 8'h00, "pend_acked");

      // Two sources pending while in service; id 1 must win over id 5.
      write_reg(REG_MASK, 8'h26);
      write_reg(REG_EDGE, 8'h26);
      src = 8'h22;
      idle(2);
      src = 8'h00;
      idle(2);
      check_output("service_masks_irq", irq, 1'b0);
      read_exp(BASE + 16'd0, 8'h22, "pend_two");
      write_reg(REG_EOI, 8'h00);
      check_output("eoi_reassert", irq, 1'b1);
      read_exp(VEC_LO, 8'h42, "prio_id1");
      read_exp(VEC_HI, 8'h12, "prio_hi1");
      write_reg(REG_EOI, 8'h00);
      check_output("eoi_second", irq, 1'b1);
      read_exp(VEC_LO, 8'h4A, "prio_id5");
      bus_cycle(16'h0000, 1'b0, 8'h00);
      read_exp(BASE + 16'd4, 8'h85, "active_abort");
      write_reg(REG_EOI, 8'h00);
      check_output("all_served", irq, 1'b0);

      // BRK: vector fetch without a request is passed through untouched.
      bus_cycle(VEC_LO, 1'b0, 8'h00);
      bus_cycle(VEC_HI, 1'b0, 8'h00);
      read_exp(BASE + 16'd4, 8'h05, "brk_active");

      // Collision: W1C lands in the cycle the rising edge is detected.
      write_reg(REG_EDGE, 8'h27);
      write_reg(REG_MASK, 8'h01);
      src = 8'h01;
      idle(2);
      src = 8'h00;
      write_reg(REG_PEND, 8'h01);
      read_exp(BASE + 16'd0, 8'h01, "collision_pend");
      check_output("collision_irq", irq, 1'b1);
      bus_cycle(16'hFFFC, 1'b0, 8'h00);
      bus_cycle(16'hFFFA, 1'b0, 8'h00);
      check_output("nmi_vec_no_ack", irq, 1'b1);
      read_exp(VEC_LO, 8'h40, "vec_src0");
      read_exp(VEC_HI, 8'h12, "vec_hi0");
      write_reg(REG_EOI, 8'h00);
      check_output("src0_done", irq, 1'b0);

      // Level source that drops before the fetch leaves nothing to vector.
      write_reg(REG_MASK, 8'h08);
      src = 8'h08;
      idle(3);
      check_output("level_irq", irq, 1'b1);
      src = 8'h00;
      idle(3);
      check_output("level_drop", irq, 1'b0);
      bus_cycle(VEC_LO, 1'b0, 8'h00);
      bus_cycle(VEC_HI, 1'b0, 8'h00);
      read_exp(BASE + 16'd4, 8'h00, "level_no_vector");

      // Enter service on a level source, then reset asynchronously mid-cycle.
      src = 8'h08;
      idle(3);
      read_exp(VEC_LO, 8'h46, "level_vec");
      read_exp(VEC_HI, 8'h12, "level_hi");
      read_exp(BASE + 16'd4, 8'h83, "active_level");
      #5 reset_n = 1'b0;
      #1;
      check_output("rst_async_sel", DI_sel, 1'b0);
      check_byte("rst_async_di", DI, 8'h00);
      check_output("rst_async_irq", irq, 1'b0);
      idle(2);
      #3 reset_n = 1'b1;
      read_exp(BASE + 16'd4, 8'h00, "rst_active");
      read_exp(BASE + 16'd1, 8'h00, "rst_mask");
      check_output("rst_irq_after", irq, 1'b0);

      idle(3);
      while (exp_name.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: no DI_sel response, required DI=%02h at cycle %0d",
                  exp_name[0], exp_data[0], exp_cyc[0]);
         void'(exp_name.pop_front());
         void'(exp_data.pop_front());
         void'(exp_cyc.pop_front());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
